// File: rtl/cfi_pkg.sv
// Shared types and constants for the CFI checking pipeline.
//   cfi_commit_log_t  : one logged control-flow instruction (pc + target)
//   exception_t       : exception record handed to the commit stage
//   cfi_sched_state_e : dispatch controller states
package cfi_pkg;

    localparam int XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] addr_pc;
        logic [XLEN-1:0] target;
    } cfi_commit_log_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] tval;
    } exception_t;

    localparam logic [XLEN-1:0] CFI_FAULT_CAUSE   = 32'd24;
    localparam logic [XLEN-1:0] CFI_TIMEOUT_CAUSE = 32'd25;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FAULT = 2'd1,
        FLUSH = 2'd2
    } cfi_sched_state_e;

endpackage

// File: rtl/cfi_rr_arbiter.sv
// Round-robin pick among N requesters.
//   clk_i, rst_ni : clock, async active-low reset
//   req_i         : request vector
//   gnt_en_i      : grant is consumed this cycle; advance the pointer
//   gnt_o         : one-hot grant (zero when no request)
// The pointer holds the index searched first; after a consumed grant it
// moves to the slot just past the winner, so reset favours index 0.
module cfi_rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [N-1:0] req_i,
    input  logic         gnt_en_i,
    output logic [N-1:0] gnt_o
);

    localparam int PW = $clog2(N);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] gidx;
    logic          found;

    // Two passes: indices at/after the pointer first, then the wrapped ones.
    always_comb begin
        gnt_o = '0;
        gidx  = '0;
        found = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!found && j >= int'(ptr_q) && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                gidx     = PW'(j);
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!found && j < int'(ptr_q) && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                gidx     = PW'(j);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (gnt_en_i && found) begin
            ptr_q <= (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;
        end
    end

endmodule

// File: rtl/cfi_backend_sched.sv
// Dispatch controller between the CFI log queue and NR_BACKENDS checkers.
// Issues queue entries round-robin to free backends, retires results in
// dispatch order via tickets, and raises one held exception on the first
// faulting or timed-out entry.
//   clk_i, rst_ni           : clock, async active-low reset
//   enable_i                : dispatch enable
//   queue_empty_i/data_i    : fall-through queue head; queue_pop_o pops it
//   be_log_o, be_valid_o    : shared issue bus and one-hot issue strobe
//   be_ready_i/done_i/fault_i : backend handshake
//   cfi_fault_o, fault_ack_i  : exception towards commit and its ack
//   busy_o                  : queue non-empty or anything in flight
//
// state | meaning
// RUN   | dispatch and in-order retirement
// FAULT | exception held on cfi_fault_o until acked, no dispatch
// FLUSH | drop remaining in-flight results, then resync tickets
module cfi_backend_sched
    import cfi_pkg::*;
#(
    parameter int NR_BACKENDS    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   enable_i,
    input  logic                   queue_empty_i,
    input  cfi_commit_log_t        queue_data_i,
    output logic                   queue_pop_o,
    output cfi_commit_log_t        be_log_o,
    output logic [NR_BACKENDS-1:0] be_valid_o,
    input  logic [NR_BACKENDS-1:0] be_ready_i,
    input  logic [NR_BACKENDS-1:0] be_done_i,
    input  logic [NR_BACKENDS-1:0] be_fault_i,
    output exception_t             cfi_fault_o,
    input  logic                   fault_ack_i,
    output logic                   busy_o
);

    localparam int N  = NR_BACKENDS;
    localparam int TW = $clog2(N) + 1;
    localparam int WW = $clog2(TIMEOUT_CYCLES);

    cfi_sched_state_e state_q, state_d;

    logic [N-1:0]    inflight_q, done_q, fault_q;
    logic [TW-1:0]   tkt_q [N];
    logic [XLEN-1:0] pc_q  [N];
    logic [TW-1:0]   issue_tkt_q, head_tkt_q;
    logic [WW-1:0]   wd_q;
    exception_t      exc_q;

    logic [N-1:0]    cand, grant, done_eff, is_head;
    logic            dispatch, head_done, head_fault, retire, timeout;
    logic [XLEN-1:0] head_pc;

    assign cand = ~inflight_q & be_ready_i;
    // Gated by rst_ni so the issue strobes are quiet while held in reset.
    assign dispatch = rst_ni && (state_q == RUN) && enable_i && !queue_empty_i && (|cand);

    cfi_rr_arbiter #(.N(N)) u_rr (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_i    (cand),
        .gnt_en_i (dispatch),
        .gnt_o    (grant)
    );

    assign be_valid_o  = dispatch ? grant : '0;
    assign queue_pop_o = dispatch;
    assign be_log_o    = queue_data_i;
    assign cfi_fault_o = exc_q;
    assign busy_o      = rst_ni && (!queue_empty_i || (|inflight_q));

    // A done pulse on the head retires in the same cycle it arrives, so a
    // fault reaches cfi_fault_o one cycle later; other pulses are latched.
    assign done_eff = done_q | (inflight_q & be_done_i);

    always_comb begin
        head_fault = 1'b0;
        head_pc    = '0;
        for (int k = 0; k < N; k++) begin
            is_head[k] = inflight_q[k] && (tkt_q[k] == head_tkt_q);
            if (is_head[k]) begin
                head_fault = done_q[k] ? fault_q[k] : be_fault_i[k];
                head_pc    = pc_q[k];
            end
        end
    end

    assign head_done = |(is_head & done_eff);
    assign retire    = (state_q == RUN) && head_done;
    // Fires on the edge where the counter would reach TIMEOUT_CYCLES-1.
    assign timeout   = (state_q == RUN) && (|is_head) && !head_done &&
                       (wd_q == WW'(TIMEOUT_CYCLES - 2));

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if ((retire && head_fault) || timeout) state_d = FAULT;
            FAULT:   if (fault_ack_i) state_d = FLUSH;
            FLUSH:   if (inflight_q == '0) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= RUN;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight_q  <= '0;
            done_q      <= '0;
            fault_q     <= '0;
            issue_tkt_q <= '0;
            head_tkt_q  <= '0;
            wd_q        <= '0;
            exc_q       <= '0;
            for (int k = 0; k < N; k++) begin
                tkt_q[k] <= '0;
                pc_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (dispatch && grant[k]) begin
                    inflight_q[k] <= 1'b1;
                    done_q[k]     <= 1'b0;
                    fault_q[k]    <= 1'b0;
                    tkt_q[k]      <= issue_tkt_q;
                    pc_q[k]       <= queue_data_i.addr_pc;
                end else if (inflight_q[k]) begin
                    if ((is_head[k] && (retire || timeout)) ||
                        (state_q == FLUSH && done_eff[k])) begin
                        inflight_q[k] <= 1'b0;
                        done_q[k]     <= 1'b0;
                        fault_q[k]    <= 1'b0;
                    end else if (be_done_i[k]) begin
                        done_q[k]  <= 1'b1;
                        fault_q[k] <= be_fault_i[k];
                    end
                end
            end

            if (dispatch) issue_tkt_q <= issue_tkt_q + 1'b1;

            if (retire || timeout) begin
                head_tkt_q <= head_tkt_q + 1'b1;
            end else if (state_q == FLUSH && inflight_q == '0) begin
                head_tkt_q <= issue_tkt_q;
            end

            if ((state_q == RUN) && (|is_head) && !head_done && !timeout) begin
                wd_q <= wd_q + 1'b1;
            end else begin
                wd_q <= '0;
            end

            if (retire && head_fault) begin
                exc_q <= '{valid: 1'b1, cause: CFI_FAULT_CAUSE, tval: head_pc};
            end else if (timeout) begin
                exc_q <= '{valid: 1'b1, cause: CFI_TIMEOUT_CAUSE, tval: head_pc};
            end else if (state_q == FAULT && fault_ack_i) begin
                exc_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_cfi_backend_sched.sv
module tb_cfi_backend_sched;
    import cfi_pkg::*;

    logic            clk = 1'b0;
    logic            rst_ni = 1'b0;
    logic            enable_i = 1'b0;
    logic            queue_empty_i = 1'b1;
    cfi_commit_log_t queue_data_i = '0;
    logic            queue_pop_o;
    cfi_commit_log_t be_log_o;
    logic [1:0]      be_valid_o;
    logic [1:0]      be_ready_i = '0;
    logic [1:0]      be_done_i = '0;
    logic [1:0]      be_fault_i = '0;
    exception_t      cfi_fault_o;
    logic            fault_ack_i = 1'b0;
    logic            busy_o;

    cfi_backend_sched #(.NR_BACKENDS(2), .TIMEOUT_CYCLES(16)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .enable_i      (enable_i),
        .queue_empty_i (queue_empty_i),
        .queue_data_i  (queue_data_i),
        .queue_pop_o   (queue_pop_o),
        .be_log_o      (be_log_o),
        .be_valid_o    (be_valid_o),
        .be_ready_i    (be_ready_i),
        .be_done_i     (be_done_i),
        .be_fault_i    (be_fault_i),
        .cfi_fault_o   (cfi_fault_o),
        .fault_ack_i   (fault_ack_i),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [1:0] grant; logic [31:0] pc; } disp_t;
    typedef struct { logic [31:0] cause; logic [31:0] tval; } exc_t;

    logic [31:0] qpc[$];
    disp_t       exp_disp[$];
    exc_t        exp_exc[$];

    int tests = 0, fails = 0;
    int cyc = 0, disp_cnt = 0, disp_cyc = 0, rises = 0, rise_cyc = 0;
    logic fault_prev = 1'b0;

    task automatic drive_queue();
        queue_empty_i = (qpc.size() == 0);
        queue_data_i  = '0;
        if (qpc.size() > 0) begin
            queue_data_i.addr_pc = qpc[0];
            queue_data_i.target  = qpc[0] + 32'h40;
        end
    endtask

    task automatic push_entry(input logic [31:0] pc, input logic [1:0] grant);
        disp_t d;
        d.grant = grant;
        d.pc    = pc;
        qpc.push_back(pc);
        exp_disp.push_back(d);
        drive_queue();
    endtask

    task automatic push_exc(input logic [31:0] cause, input logic [31:0] tval);
        exc_t e;
        e.cause = cause;
        e.tval  = tval;
        exp_exc.push_back(e);
    endtask

    // One clock: sample on the falling edge, score dispatches and exception
    // rises against the scoreboards, then advance past the rising edge.
    task automatic tick();
        disp_t d;
        exc_t  e;
        @(negedge clk);
        if (queue_pop_o === 1'b1) begin
            disp_cnt++;
            disp_cyc = cyc;
            tests++;
            if (exp_disp.size() == 0) begin
                fails++;
                $display("FAIL dispatch_unexpected: got grant %b pc %h, required no dispatch", be_valid_o, be_log_o.addr_pc);
            end else begin
                d = exp_disp.pop_front();
                if (be_valid_o !== d.grant || be_log_o.addr_pc !== d.pc) begin
                    fails++;
                    $display("FAIL dispatch: got grant %b pc %h, required grant %b pc %h", be_valid_o, be_log_o.addr_pc, d.grant, d.pc);
                end
            end
            if (qpc.size() > 0) void'(qpc.pop_front());
        end
        if (cfi_fault_o.valid === 1'b1 && !fault_prev) begin
            rises++;
            rise_cyc = cyc;
            tests++;
            if (exp_exc.size() == 0) begin
                fails++;
                $display("FAIL exception_unexpected: got cause %0d tval %h, required none", cfi_fault_o.cause, cfi_fault_o.tval);
            end else begin
                e = exp_exc.pop_front();
                if (cfi_fault_o.cause !== e.cause || cfi_fault_o.tval !== e.tval) begin
                    fails++;
                    $display("FAIL exception: got cause %0d tval %h, required cause %0d tval %h", cfi_fault_o.cause, cfi_fault_o.tval, e.cause, e.tval);
                end
            end
        end
        fault_prev = (cfi_fault_o.valid === 1'b1);
        @(posedge clk);
        cyc++;
        #1;
        drive_queue();
    endtask

    task automatic wait_disp(input int target, input string name);
        int budget = 20;
        while (disp_cnt < target && budget > 0) begin
            tick();
            budget--;
        end
        if (disp_cnt < target) begin
            tests++;
            fails++;
            $display("FAIL %s_dispatch_timeout: got %0d dispatches, required %0d", name, disp_cnt, target);
        end
    endtask

    task automatic pulse_done(input logic [1:0] done, input logic [1:0] fault);
        be_done_i  = done;
        be_fault_i = fault;
        tick();
        be_done_i  = '0;
        be_fault_i = '0;
    endtask

    task automatic drained(input string name);
        tests++;
        if (exp_disp.size() != 0 || exp_exc.size() != 0) begin
            fails++;
            $display("FAIL %s_scoreboard: got %0d dispatches %0d exceptions outstanding, required 0 0", name, exp_disp.size(), exp_exc.size());
        end
    endtask

    task automatic do_reset();
        rst_ni      = 1'b0;
        enable_i    = 1'b1;
        be_ready_i  = '0;
        be_done_i   = '0;
        be_fault_i  = '0;
        fault_ack_i = 1'b0;
        qpc.delete();
        exp_disp.delete();
        exp_exc.delete();
        drive_queue();
        repeat (2) @(posedge clk);
        #1;
        rst_ni     = 1'b1;
        fault_prev = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst_ni = 1'b0;
        qpc.push_back(32'h1234);
        drive_queue();
        be_ready_i = 2'b11;
        #1;
        tests++;
        if (queue_pop_o !== 1'b0 || be_valid_o !== 2'b00 || cfi_fault_o !== '0 || busy_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: got pop %b valid %b fault %h busy %b, required all 0", queue_pop_o, be_valid_o, cfi_fault_o, busy_o);
        end
        qpc.delete();
        drive_queue();
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic test_single();
        int r0;
        do_reset();
        r0 = rises;
        be_ready_i = 2'b01;
        push_entry(32'h0000_1000, 2'b01);
        wait_disp(disp_cnt + 1, "single");
        repeat (4) tick();
        pulse_done(2'b01, 2'b00);
        #1;
        tests++;
        if (busy_o !== 1'b0) begin
            fails++;
            $display("FAIL single_busy: got %b, required 0", busy_o);
        end
        repeat (3) tick();
        tests++;
        if (rises != r0) begin
            fails++;
            $display("FAIL single_no_fault: got %0d exception rises, required 0", rises - r0);
        end
        drained("single");
    endtask

    task automatic test_ooo();
        int base, fc;
        do_reset();
        base = disp_cnt;
        be_ready_i = 2'b11;
        push_entry(32'h0000_2000, 2'b01);
        push_entry(32'h0000_2004, 2'b10);
        push_entry(32'h8000_1000, 2'b01);
        push_entry(32'h0000_200c, 2'b10);
        wait_disp(base + 2, "ooo_first");
        pulse_done(2'b10, 2'b00);
        #1;
        tests++;
        if (queue_pop_o !== 1'b0) begin
            fails++;
            $display("FAIL ooo_pool_full: got pop %b, required 0", queue_pop_o);
        end
        pulse_done(2'b01, 2'b00);
        wait_disp(base + 4, "ooo_second");
        tests++;
        if (rises != 0) begin
            fails++;
            $display("FAIL ooo_early_fault: got %0d rises, required 0", rises);
        end
        push_exc(CFI_FAULT_CAUSE, 32'h8000_1000);
        fc = cyc;
        pulse_done(2'b01, 2'b01);
        tick();
        tests++;
        if (rises != 1 || rise_cyc != fc + 1) begin
            fails++;
            $display("FAIL ooo_fault_latency: got rises %0d at cycle %0d, required 1 at cycle %0d", rises, rise_cyc, fc + 1);
        end
        fault_ack_i = 1'b1;
        tick();
        fault_ack_i = 1'b0;
        pulse_done(2'b10, 2'b10);
        repeat (3) tick();
        #1;
        tests++;
        if (rises != 1 || busy_o !== 1'b0 || cfi_fault_o.valid !== 1'b0) begin
            fails++;
            $display("FAIL ooo_flush: got rises %0d busy %b valid %b, required 1 0 0", rises, busy_o, cfi_fault_o.valid);
        end
        drained("ooo");
    endtask

    task automatic test_full_pool();
        int base, dc;
        do_reset();
        base = disp_cnt;
        be_ready_i = 2'b11;
        push_entry(32'h0000_3000, 2'b01);
        push_entry(32'h0000_3004, 2'b10);
        push_entry(32'h0000_3008, 2'b01);
        wait_disp(base + 2, "full");
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++;
            if (queue_pop_o !== 1'b0 || queue_empty_i !== 1'b0) begin
                fails++;
                $display("FAIL full_pool_hold: got pop %b empty %b, required pop 0 empty 0", queue_pop_o, queue_empty_i);
            end
            tick();
        end
        dc = cyc;
        pulse_done(2'b01, 2'b00);
        tick();
        tests++;
        if (disp_cnt != base + 3 || disp_cyc != dc + 1) begin
            fails++;
            $display("FAIL full_pool_reuse: got %0d dispatches last at cycle %0d, required %0d at cycle %0d", disp_cnt - base, disp_cyc, 3, dc + 1);
        end
        pulse_done(2'b10, 2'b00);
        pulse_done(2'b01, 2'b00);
        tick();
        drained("full");
    endtask

    task automatic test_timeout();
        int r0, budget;
        do_reset();
        r0 = rises;
        be_ready_i = 2'b01;
        push_exc(CFI_TIMEOUT_CAUSE, 32'h0000_4000);
        push_entry(32'h0000_4000, 2'b01);
        wait_disp(disp_cnt + 1, "timeout");
        budget = 30;
        while (rises == r0 && budget > 0) begin
            tick();
            budget--;
        end
        tests++;
        if (rises != r0 + 1 || rise_cyc != disp_cyc + 16) begin
            fails++;
            $display("FAIL timeout_latency: got rise at cycle %0d (%0d rises), required cycle %0d", rise_cyc, rises - r0, disp_cyc + 16);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if (cfi_fault_o.valid !== 1'b1) begin
                fails++;
                $display("FAIL timeout_hold: got valid %b, required 1", cfi_fault_o.valid);
            end
        end
        fault_ack_i = 1'b1;
        tick();
        fault_ack_i = 1'b0;
        tests++;
        if (cfi_fault_o.valid !== 1'b0) begin
            fails++;
            $display("FAIL timeout_ack: got valid %b, required 0", cfi_fault_o.valid);
        end
        repeat (3) tick();
        drained("timeout");
    endtask

    task automatic test_flush();
        int base, r0, dc;
        do_reset();
        base = disp_cnt;
        r0 = rises;
        be_ready_i = 2'b11;
        push_entry(32'h0000_5000, 2'b01);
        push_entry(32'h0000_5004, 2'b10);
        wait_disp(base + 2, "flush");
        push_entry(32'h0000_5008, 2'b01);
        push_exc(CFI_FAULT_CAUSE, 32'h0000_5000);
        pulse_done(2'b01, 2'b01);
        fault_ack_i = 1'b1;
        tick();
        fault_ack_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++;
            if (queue_pop_o !== 1'b0) begin
                fails++;
                $display("FAIL flush_no_dispatch: got pop %b, required 0", queue_pop_o);
            end
            tick();
        end
        dc = cyc;
        pulse_done(2'b10, 2'b10);
        wait_disp(base + 3, "flush_resume");
        tests++;
        if (disp_cyc <= dc || rises != r0 + 1) begin
            fails++;
            $display("FAIL flush_discard: got dispatch cycle %0d rises %0d, required after %0d with rises %0d", disp_cyc, rises - r0, dc, 1);
        end
        pulse_done(2'b01, 2'b00);
        tick();
        drained("flush");
    endtask

    task automatic test_reset_mid();
        int base, r0;
        do_reset();
        base = disp_cnt;
        be_ready_i = 2'b11;
        push_entry(32'h0000_6000, 2'b01);
        push_entry(32'h0000_6004, 2'b10);
        push_entry(32'h0000_6008, 2'b01);
        wait_disp(base + 2, "rstmid");
        rst_ni = 1'b0;
        #1;
        tests++;
        if (queue_pop_o !== 1'b0 || be_valid_o !== 2'b00 || cfi_fault_o !== '0 || busy_o !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_outputs: got pop %b valid %b fault %h busy %b, required all 0", queue_pop_o, be_valid_o, cfi_fault_o, busy_o);
        end
        tick();
        rst_ni = 1'b1;
        fault_prev = 1'b0;
        r0 = rises;
        wait_disp(base + 3, "rstmid_resume");
        // Entry now on backend 0 must be the head (ticket 0) to fault at once.
        push_exc(CFI_FAULT_CAUSE, 32'h0000_6008);
        pulse_done(2'b01, 2'b01);
        tick();
        tests++;
        if (rises != r0 + 1) begin
            fails++;
            $display("FAIL rstmid_ticket0: got %0d rises, required 1", rises - r0);
        end
        fault_ack_i = 1'b1;
        tick();
        fault_ack_i = 1'b0;
        repeat (2) tick();
        drained("rstmid");
    endtask

    initial begin
        test_reset();
        test_single();
        test_ooo();
        test_full_pool();
        test_timeout();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got simulation still running, required finish");
        $fatal(1);
    end

endmodule
